ifu_fetch_queue: RTL and testbench
==================================

# ifu_fetch_queue

Parametrised instruction-fetch front end with a decoupling fetch queue. It sits between the ICache lookup port and the IDU. It holds a fetch PC and issues it to the cache every cycle. On each hit it predicts the next PC statically and pushes `{pc, inst, pred_taken}` into a `DEPTH`-entry FIFO that decouples cache hits from IDU back-pressure. Redirects from EXU jumps and CSR traps flush the queue; a redirect that arrives during a cache refill is deferred until the refill completes.

## Interface
Parameters:
- `DEPTH`, 4: fetch-queue entries; power of two, ≥ 2.
- `RESET_PC`, 32'h8000_0000: fetch PC loaded at reset.
- `PRED_MODE`, 1: 0 = always pc+4; 1 = backward conditional branches taken; 2 = mode 1 plus JAL taken.

Ports:
- `clock`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `fetch_addr`  out  32  PC presented to the ICache; equals the fetch_pc register.
- `cache_hit`  in  1  ICache hit for `fetch_addr`, same cycle.
- `cache_inst`  in  32  instruction for `fetch_addr`; valid when `cache_hit`.
- `flush`  in  1  redirect request (jump or CSR/trap, already merged upstream).
- `flush_pc`  in  32  redirect target; sampled when `flush`.
- `out_valid`  out  1  head entry valid toward the IDU.
- `out_ready`  in  1  IDU accepts the head entry.
- `out_pc`  out  32  head PC.
- `out_inst`  out  32  head instruction.
- `out_pred_taken`  out  1  head entry was predicted taken.
- `count`  out  $clog2(DEPTH+1)  current queue occupancy.

## Operation
- Registers:
  - `fetch_pc`.
  - `pend` (1 bit) and `pend_pc`.
  - Queue storage, head and tail pointers of `$clog2(DEPTH)` bits (wrap modulo `DEPTH`), and `count`.
- Pop: `out_valid & out_ready`. `out_valid = (count != 0) & ~flush & ~pend`.
- Push condition: `cache_hit & ~flush & ~pend & (count < DEPTH | pop)`. A push and a pop in the same cycle when full is legal; `count` stays `DEPTH`.
- On push, `fetch_pc <= next_pc`. If the queue is full with no pop, or on a miss, `fetch_pc` holds.
- Next-PC prediction, decoded from `cache_inst`:
  - B-type (opcode 1100011) with `inst[31]=1` and `PRED_MODE≥1`: `pc + imm_b`, taken = 1.
  - JAL (1101111) with `PRED_MODE=2`: `pc + imm_j`, taken = 1.
  - Otherwise: `pc + 4`, taken = 0.
  - All arithmetic is 32-bit modulo 2^32.
- `flush` with `cache_hit=1` (no refill in flight):
  - Queue cleared (`count=0`, head = tail = 0), no push.
  - `fetch_pc <= flush_pc` the next cycle.
- `flush` with `cache_hit=0`:
  - Queue cleared, `pend <= 1`, `pend_pc <= flush_pc`.
  - `fetch_addr` holds so the in-flight refill completes at a stable address.
- While `pend=1`:
  - No push and no pop.
  - On `cache_hit`: the instruction is discarded, `fetch_pc <= pend_pc`, `pend <= 0`.
  - A new `flush` during `pend` overwrites `pend_pc`, latest wins. If it coincides with the releasing hit, `fetch_pc <= flush_pc` (the new one).
- `flush` has priority over push and pop in the same cycle. A pop offered in a flush cycle is not taken because `out_valid` is 0.
- Reset values:
  - `fetch_pc = RESET_PC`, `pend = 0`, `count = 0`.
  - `out_valid = 0`.
  - `out_pc`, `out_inst` and `out_pred_taken` are 0 (storage cleared).

## Timing
- Hit in cycle N at an empty queue: `out_valid=1` in cycle N+1 with that entry. Steady state is one instruction per cycle when hits are continuous and `out_ready=1`.
- Flush in cycle N with a hit: `fetch_addr = flush_pc` in N+1. The first post-flush entry is valid in N+2 if that access hits.
- Flush during a miss: `fetch_addr` is unchanged until the refill hit in cycle M. `fetch_addr = pend_pc` in M+1.
- `out_*` come straight from registered storage at the head; no combinational path from `cache_inst` to `out_*`. `out_valid` has a combinational path from `flush`.
- `count`: +1 on push only, −1 on pop only, unchanged on both or neither, 0 after flush.

## Test plan
- Reset with `RESET_PC=32'h3000_0000` → `fetch_addr=32'h3000_0000`, `out_valid=0`, `count=0`. Then constant hits with `inst=32'h0000_0013` → `out_pc` sequence 0x30000000, 0x30000004, … one per cycle.
- `DEPTH=4`, `out_ready=0`, constant hits → `count` saturates at 4 after four cycles and `fetch_addr` holds at base+16. Raise `out_ready` → one pop and one push per cycle, `count` stays 4, output order is preserved.
- Flush with `flush_pc=32'h8000_0100` while `count=3` and hit → `out_valid=0` in the same cycle, `count=0` next cycle, next `fetch_addr=32'h8000_0100`, and no stale PC appears at the output.
- Miss at 0x80000040, flush to 0x80000200 at cycle 2, second flush to 0x80000300 at cycle 4, hit at cycle 6 → `fetch_addr` stays 0x80000040 through cycle 6, the 0x80000040 instruction is never output, and `fetch_addr=32'h8000_0300` at cycle 7.
- `PRED_MODE=1`, `inst=32'hFE00_0EE3` (beq, offset −4) at 0x80000010 → next `fetch_addr=32'h8000_000C`, `out_pred_taken=1`. A forward branch at the same PC → 0x80000014, `out_pred_taken=0`.
- `PRED_MODE=2`, JAL with offset +0x100 at 0x80000000 → next `fetch_addr=32'h8000_0100`. With `PRED_MODE=0` the same JAL → 0x80000004.

Source files
------------

// File: rtl/ifu_fetch_queue.sv
// ifu_fetch_queue: fetch PC sequencer with static next-PC prediction and a decoupling instruction queue
module ifu_fetch_queue #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] RESET_PC  = 32'h8000_0000,
    parameter int          PRED_MODE = 1
) (
    input  logic                       clock,
    input  logic                       reset,
    output logic [31:0]                fetch_addr,
    input  logic                       cache_hit,
    input  logic [31:0]                cache_inst,
    input  logic                       flush,
    input  logic [31:0]                flush_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_pc,
    output logic [31:0]                out_inst,
    output logic                       out_pred_taken,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]   fetch_pc, pend_pc, next_pc, imm_b, imm_j;
    logic          pend, pop, push, br_tk, jal_tk;
    logic [31:0]   q_pc   [DEPTH];
    logic [31:0]   q_inst [DEPTH];
    logic          q_tk   [DEPTH];
    logic [AW-1:0] head, tail;

    assign fetch_addr     = fetch_pc;
    assign out_valid      = (count != '0) & ~flush & ~pend;
    assign pop            = out_valid & out_ready;
    assign push           = cache_hit & ~flush & ~pend & ((count < CW'(DEPTH)) | pop);
    assign out_pc         = q_pc[head];
    assign out_inst       = q_inst[head];
    assign out_pred_taken = q_tk[head];

    always_comb begin
        imm_b   = {{20{cache_inst[31]}}, cache_inst[7], cache_inst[30:25], cache_inst[11:8], 1'b0};
        imm_j   = {{12{cache_inst[31]}}, cache_inst[19:12], cache_inst[20], cache_inst[30:21], 1'b0};
        br_tk   = (cache_inst[6:0] == 7'b1100011) & cache_inst[31] & (PRED_MODE >= 1);
        jal_tk  = (cache_inst[6:0] == 7'b1101111) & (PRED_MODE == 2);
        next_pc = br_tk ? fetch_pc + imm_b : jal_tk ? fetch_pc + imm_j : fetch_pc + 32'd4;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            pend     <= 1'b0;
            pend_pc  <= '0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_pc[i]   <= '0;
                q_inst[i] <= '0;
                q_tk[i]   <= 1'b0;
            end
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            // A redirect without a hit must wait for the in-flight refill at the current address
            if (cache_hit) begin
                fetch_pc <= flush_pc;
                pend     <= 1'b0;
            end else begin
                pend     <= 1'b1;
                pend_pc  <= flush_pc;
            end
        end else if (pend) begin
            if (cache_hit) begin
                fetch_pc <= pend_pc;
                pend     <= 1'b0;
            end
        end else begin
            if (push) begin
                q_pc[tail]   <= fetch_pc;
                q_inst[tail] <= cache_inst;
                q_tk[tail]   <= br_tk | jal_tk;
                tail         <= tail + AW'(1);
                fetch_pc     <= next_pc;
            end
            if (pop)
                head <= head + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: tb/tb_ifu_fetch_queue.sv
// tb_ifu_fetch_queue: directed checks of fetch sequencing, queue occupancy, flush/pending redirect and prediction
module tb_ifu_fetch_queue;
    logic        clock = 1'b0;
    logic        reset, cache_hit, flush, out_ready;
    logic [31:0] cache_inst, flush_pc;
    logic [31:0] fetch_addr, out_pc, out_inst, m0_fetch_addr, m0_out_pc, m0_out_inst;
    logic        out_valid, out_pred_taken, m0_out_valid, m0_out_pred_taken;
    logic [2:0]  count, m0_count;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clock = ~clock;

    ifu_fetch_queue #(.DEPTH(4), .RESET_PC(32'h3000_0000), .PRED_MODE(2)) u_dut (
        .clock(clock), .reset(reset), .fetch_addr(fetch_addr), .cache_hit(cache_hit),
        .cache_inst(cache_inst), .flush(flush), .flush_pc(flush_pc), .out_valid(out_valid),
        .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
        .out_pred_taken(out_pred_taken), .count(count)
    );

    ifu_fetch_queue #(.DEPTH(4), .RESET_PC(32'h3000_0000), .PRED_MODE(0)) u_m0 (
        .clock(clock), .reset(reset), .fetch_addr(m0_fetch_addr), .cache_hit(cache_hit),
        .cache_inst(cache_inst), .flush(flush), .flush_pc(flush_pc), .out_valid(m0_out_valid),
        .out_ready(out_ready), .out_pc(m0_out_pc), .out_inst(m0_out_inst),
        .out_pred_taken(m0_out_pred_taken), .count(m0_count)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; cache_hit = 1'b0; flush = 1'b0; out_ready = 1'b0;
        cache_inst = 32'h0000_0013; flush_pc = '0;
        tick(); tick();
        reset = 1'b0;
        #1;
        chk("rst_fetch_addr", fetch_addr, 32'h3000_0000);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_count", count, 0);
        chk("rst_out_pc", out_pc, 0);
        chk("rst_out_inst", out_inst, 0);
        chk("rst_out_pred", out_pred_taken, 0);

        // streaming: one entry per cycle
        cache_hit = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("stream_valid", out_valid, 1);
            chk("stream_pc", out_pc, 32'h3000_0000 + 32'(4 * k));
            chk("stream_count", count, 1);
        end
        chk("stream_inst", out_inst, 32'h0000_0013);
        chk("stream_fetch", fetch_addr, 32'h3000_0010);

        // back-pressure: fill to DEPTH and hold
        out_ready = 1'b0;
        tick(); chk("fill_count1", count, 2);
        tick(); chk("fill_count2", count, 3);
        tick(); chk("fill_count3", count, 4); chk("fill_fetch3", fetch_addr, 32'h3000_001C);
        tick(); chk("fill_count4", count, 4); chk("fill_fetch4", fetch_addr, 32'h3000_001C);
        tick(); chk("fill_fetch5", fetch_addr, 32'h3000_001C);
        chk("fill_head", out_pc, 32'h3000_000C);

        // full with simultaneous push and pop
        out_ready = 1'b1;
        tick(); chk("fullpp_pc1", out_pc, 32'h3000_0010); chk("fullpp_count1", count, 4);
        chk("fullpp_fetch1", fetch_addr, 32'h3000_0020);
        tick(); chk("fullpp_pc2", out_pc, 32'h3000_0014); chk("fullpp_count2", count, 4);

        // drain one so count is 3, then flush with hit
        cache_hit = 1'b0;
        tick(); chk("drain_count", count, 3); chk("drain_pc", out_pc, 32'h3000_0018);
        cache_hit = 1'b1; flush = 1'b1; flush_pc = 32'h8000_0100;
        #1; chk("flush_valid_comb", out_valid, 0);
        tick();
        flush = 1'b0;
        #1;
        chk("flush_count", count, 0);
        chk("flush_valid", out_valid, 0);
        chk("flush_fetch", fetch_addr, 32'h8000_0100);
        tick();
        chk("postflush_valid", out_valid, 1);
        chk("postflush_pc", out_pc, 32'h8000_0100);

        // redirect to 0x80000040 then miss there; two flushes during the refill
        flush = 1'b1; flush_pc = 32'h8000_0040;
        tick();
        flush = 1'b0; cache_hit = 1'b0;
        tick();
        tick();
        flush = 1'b1; flush_pc = 32'h8000_0200;
        tick();
        flush = 1'b0;
        #1; chk("pend_fetch3", fetch_addr, 32'h8000_0040); chk("pend_valid3", out_valid, 0);
        tick();
        flush = 1'b1; flush_pc = 32'h8000_0300;
        tick();
        flush = 1'b0;
        #1; chk("pend_fetch5", fetch_addr, 32'h8000_0040); chk("pend_count5", count, 0);
        tick();
        cache_hit = 1'b1; cache_inst = 32'hFE00_0EE3;
        #1; chk("pend_fetch6", fetch_addr, 32'h8000_0040); chk("pend_valid6", out_valid, 0);
        tick();
        cache_inst = 32'h0000_0013;
        #1;
        chk("release_fetch", fetch_addr, 32'h8000_0300);
        chk("release_valid", out_valid, 0);
        chk("release_count", count, 0);
        tick();
        chk("release_out_pc", out_pc, 32'h8000_0300);
        chk("release_out_valid", out_valid, 1);

        // backward branch predicted taken
        flush = 1'b1; flush_pc = 32'h8000_0010;
        tick();
        flush = 1'b0; cache_inst = 32'hFE00_0EE3;
        tick();
        chk("bwd_fetch", fetch_addr, 32'h8000_000C);
        chk("bwd_pc", out_pc, 32'h8000_0010);
        chk("bwd_inst", out_inst, 32'hFE00_0EE3);
        chk("bwd_pred", out_pred_taken, 1);
        chk("bwd_m0_fetch", m0_fetch_addr, 32'h8000_0014);
        chk("bwd_m0_pred", m0_out_pred_taken, 0);

        // forward branch falls through
        flush = 1'b1; flush_pc = 32'h8000_0010;
        tick();
        flush = 1'b0; cache_inst = 32'h0000_0463;
        tick();
        chk("fwd_fetch", fetch_addr, 32'h8000_0014);
        chk("fwd_pc", out_pc, 32'h8000_0010);
        chk("fwd_pred", out_pred_taken, 0);

        // JAL +0x100
        flush = 1'b1; flush_pc = 32'h8000_0000;
        tick();
        flush = 1'b0; cache_inst = 32'h1000_006F;
        tick();
        chk("jal_fetch", fetch_addr, 32'h8000_0100);
        chk("jal_pred", out_pred_taken, 1);
        chk("jal_m0_fetch", m0_fetch_addr, 32'h8000_0004);
        chk("jal_m0_pred", m0_out_pred_taken, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
